// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int unsigned MEM_BYTES_DEFAULT = 1024;
  localparam int unsigned WORD_BYTES        = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Shifts stream bytes MSB-first into 32-bit words; word_valid marks the 4th byte.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift;
  logic [1:0]  cnt;

  // The completed word combines the three held bytes with the byte in flight.
  assign word       = {shift, din};
  assign word_valid = en && (cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      cnt   <= '0;
    end else if (clr) begin
      shift <= '0;
      cnt   <= '0;
    end else if (en) begin
      shift <= {shift[15:0], din};
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a length/data/checksum framed byte stream and writes big-endian
// instruction words into instruction memory, holding the CPU via busy.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err_checksum,
  output logic          err_overflow
);

  localparam logic [17:0]       CAP  = 18'(MEM_BYTES - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t state, state_nxt;

  logic              rdy;
  logic              xfer;
  logic              take_start;
  logic [15:0]       len;
  logic [15:0]       word_idx;
  logic [7:0]        csum_acc;
  logic [17:0]       len_x4;
  logic              overflow;
  logic              last_word;
  logic [31:0]       asm_word;
  logic              asm_valid;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [31:0]       mem_wdata_q;

  assign rdy       = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == DATA)   || (state == CSUM);
  assign xfer      = bus.byte_valid && rdy;
  assign len_x4    = {len[15:8], bus.byte_data, 2'b00};
  assign overflow  = len_x4 > CAP;
  assign last_word = (word_idx == (len - 16'd1));

  assign bus.byte_ready = rdy;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_waddr  = mem_waddr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign busy           = rdy;
  assign done           = (state == DONE);

  word_assembler u_asm (
    .clk        (CLK),
    .rst        (RESET),
    .clr        (take_start),
    .en         (xfer && (state == DATA)),
    .din        (bus.byte_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nxt  = LEN_HI;
          take_start = 1'b1;
        end
      end
      LEN_HI: if (xfer) state_nxt = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (overflow)                                  state_nxt = ERR;
          else if ({len[15:8], bus.byte_data} == 16'd0) state_nxt = CSUM;
          else                                           state_nxt = DATA;
        end
      end
      DATA:    if (asm_valid && last_word) state_nxt = CSUM;
      CSUM:    if (xfer) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write port is registered, so the last word's strobe lands in the CSUM cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      len          <= '0;
      word_idx     <= '0;
      csum_acc     <= '0;
      err_checksum <= 1'b0;
      err_overflow <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (take_start) begin
        len          <= '0;
        word_idx     <= '0;
        csum_acc     <= '0;
        err_checksum <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (xfer) begin
        case (state)
          LEN_HI: begin
            len[15:8] <= bus.byte_data;
            csum_acc  <= csum_acc ^ bus.byte_data;
          end
          LEN_LO: begin
            len[7:0] <= bus.byte_data;
            csum_acc <= csum_acc ^ bus.byte_data;
            if (overflow) err_overflow <= 1'b1;
          end
          DATA: csum_acc <= csum_acc ^ bus.byte_data;
          CSUM: if (bus.byte_data != csum_acc) err_checksum <= 1'b1;
          default: ;
        endcase
      end
      if (asm_valid) begin
        mem_we_q    <= 1'b1;
        mem_wdata_q <= asm_word;
        mem_waddr_q <= BASE + ADDR_W'(word_idx * 16'(WORD_BYTES));
        word_idx    <= word_idx + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised and directed frame loads checked against a frame-level reference model.
module tb_imem_loader;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned BASE_ADDR = 0;

  typedef logic [7:0] bq_t[$];

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic start = 1'b0;
  logic busy, done, err_checksum, err_overflow;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .bus          (bus.slave),
    .busy         (busy),
    .done         (done),
    .err_checksum (err_checksum),
    .err_overflow (err_overflow)
  );

  always #5 CLK = ~CLK;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]  imem [MEM_BYTES];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done, exp_cs, exp_ov;
  bq_t         frm;

  // Memory model of the instruction store, fed by the write strobe.
  always @(negedge CLK) begin
    if (bus.mem_we === 1'b1) begin
      int unsigned a;
      a = int'(bus.mem_waddr);
      got_addr.push_back(32'(bus.mem_waddr));
      got_data.push_back(bus.mem_wdata);
      imem[(a + 0) % MEM_BYTES] = bus.mem_wdata[31:24];
      imem[(a + 1) % MEM_BYTES] = bus.mem_wdata[23:16];
      imem[(a + 2) % MEM_BYTES] = bus.mem_wdata[15:8];
      imem[(a + 3) % MEM_BYTES] = bus.mem_wdata[7:0];
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic make_frame(input int unsigned n, input bit bad);
    logic [7:0] x;
    logic [15:0] nn;
    nn = 16'(n);
    frm = {};
    frm.push_back(nn[15:8]);
    frm.push_back(nn[7:0]);
    for (int unsigned i = 0; i < n * 4; i++) frm.push_back(8'($urandom));
    x = 8'h00;
    foreach (frm[i]) x = x ^ frm[i];
    if (bad) x = x ^ (8'h01 << $urandom_range(0, 7));
    frm.push_back(x);
  endtask

  task automatic nominal_frame(input logic [7:0] last);
    logic [7:0] arr [11] = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h10, 8'h20,
                             8'h00, 8'h64, 8'h28, 8'h24, 8'h5B};
    frm = {};
    for (int i = 0; i < 10; i++) frm.push_back(arr[i]);
    frm.push_back(last);
  endtask

  // Frame-level reference: length rule, word packing and XOR checksum.
  task automatic predict(input bq_t f);
    int unsigned n;
    logic [7:0] x;
    exp_addr = {};
    exp_data = {};
    n = (int'(f[0]) << 8) | int'(f[1]);
    exp_ov = 0; exp_cs = 0; exp_done = 0;
    if (n * 4 > MEM_BYTES - BASE_ADDR) begin
      exp_ov = 1;
    end else begin
      for (int unsigned w = 0; w < n; w++) begin
        exp_addr.push_back(32'(BASE_ADDR + 4 * w));
        exp_data.push_back({f[2 + 4*w], f[3 + 4*w], f[4 + 4*w], f[5 + 4*w]});
      end
      x = 8'h00;
      for (int unsigned i = 0; i + 1 < f.size(); i++) x = x ^ f[i];
      exp_cs   = (x != f[f.size() - 1]);
      exp_done = 1;
    end
  endtask

  // gap_mode: 0 back-to-back, 1 alternate idle cycles, 2 random idle cycles.
  task automatic drive_bytes(input string name, input bq_t s, input int gap_mode,
                             input bit busy_start);
    int unsigned i, cyc, limit;
    bit pulsed, idle;
    i = 0; cyc = 0; pulsed = 0;
    limit = s.size() * 4 + 64;
    while (i < s.size() && cyc < limit) begin
      @(negedge CLK);
      cyc++;
      start = 1'b0;
      if (busy_start && !pulsed && i == 3) begin
        start  = 1'b1;
        pulsed = 1;
      end
      idle = (gap_mode == 1) ? cyc[0] : (gap_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (idle) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = s[i];
        #1;
        if (bus.byte_ready === 1'b1) i++;
      end
    end
    vectors++;
    if (i != s.size()) begin
      miscompares++;
      $display("FAIL %s byte_accept got %0d want %0d bytes within %0d cycles", name, i, s.size(), limit);
    end
    @(negedge CLK);
    bus.byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_frame(input string name, input bq_t f, input int gap_mode,
                           input bit busy_start);
    bq_t s;
    predict(f);
    got_addr.delete();
    got_data.delete();
    s = {};
    for (int unsigned i = 0; i < (exp_ov ? 2 : f.size()); i++) s.push_back(f[i]);
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    #1;
    vectors++;
    if ({busy, bus.byte_ready, done, err_checksum, err_overflow} !== 5'b11000) begin
      miscompares++;
      $display("FAIL %s after_start busy,rdy,done,cs,ov got %b want 11000", name,
               {busy, bus.byte_ready, done, err_checksum, err_overflow});
    end
    drive_bytes(name, s, gap_mode, busy_start);
    repeat (2) @(negedge CLK);
    vectors++;
    if (got_addr.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL %s write_count got %0d want %0d", name, got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL %s write[%0d] got %h:%h want %h:%h", name, i,
                 got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    vectors++;
    if ({done, err_checksum, err_overflow, busy, bus.byte_ready} !==
        {exp_done, exp_cs, exp_ov, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s status done,cs,ov,busy,rdy got %b want %b", name,
               {done, err_checksum, err_overflow, busy, bus.byte_ready},
               {exp_done, exp_cs, exp_ov, 2'b00});
    end
  endtask

  task automatic test_reset();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({busy, done, err_checksum, err_overflow, bus.byte_ready, bus.mem_we} !== 6'b0 ||
        bus.mem_waddr !== '0 || bus.mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset outputs got %b/%h/%h want all zero",
               {busy, done, err_checksum, err_overflow, bus.byte_ready, bus.mem_we},
               bus.mem_waddr, bus.mem_wdata);
    end
    RESET = 1'b0;
    @(negedge CLK);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    #1;
    vectors++;
    if ({busy, bus.byte_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_not_ready busy,rdy got %b want 00", {busy, bus.byte_ready});
    end
    @(negedge CLK) bus.byte_valid = 1'b0;
  endtask

  task automatic test_nominal();
    logic [31:0] w0, w1;
    nominal_frame(8'h5B);
    run_frame("nominal", frm, 0, 0);
    w0 = {imem[0], imem[1], imem[2], imem[3]};
    w1 = {imem[4], imem[5], imem[6], imem[7]};
    vectors++;
    if (w0 !== 32'h00011020 || w1 !== 32'h00642824) begin
      miscompares++;
      $display("FAIL fetch pc0/pc4 got %h %h want 00011020 00642824", w0, w1);
    end
  endtask

  task automatic test_bad_checksum();
    nominal_frame(8'h5A);
    run_frame("bad_checksum", frm, 0, 0);
  endtask

  task automatic test_zero_length();
    frm = {8'h00, 8'h00, 8'h00};
    run_frame("zero_length", frm, 0, 0);
  endtask

  task automatic test_overflow();
    frm = {8'h01, 8'h01};
    run_frame("overflow", frm, 0, 0);
    nominal_frame(8'h5B);
    run_frame("after_overflow", frm, 0, 0);
  endtask

  task automatic test_full_memory();
    make_frame(MEM_BYTES / 4, 0);
    run_frame("full_memory", frm, 0, 0);
  endtask

  task automatic test_back_pressure();
    nominal_frame(8'h5B);
    run_frame("back_pressure", frm, 1, 1);
  endtask

  task automatic test_reset_mid_frame();
    bq_t s;
    nominal_frame(8'h5B);
    s = {};
    for (int i = 0; i < 5; i++) s.push_back(frm[i]);
    got_addr.delete();
    got_data.delete();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    drive_bytes("reset_mid", s, 0, 0);
    #2 RESET = 1'b1;
    #1;
    vectors++;
    if ({busy, done, err_checksum, err_overflow, bus.byte_ready, bus.mem_we} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid async outputs got %b want 000000",
               {busy, done, err_checksum, err_overflow, bus.byte_ready, bus.mem_we});
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    vectors++;
    if (got_addr.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid writes got %0d want 0", got_addr.size());
    end
    run_frame("after_reset", frm, 0, 0);
  endtask

  task automatic test_random();
    int unsigned n;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 5) == 0) n = $urandom_range(MEM_BYTES / 4 + 1, 65535);
      else n = $urandom_range(0, 6);
      make_frame(n, $urandom_range(0, 3) == 0);
      run_frame($sformatf("random%0d", k), frm, int'($urandom_range(0, 2)),
                $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_zero_length();
    test_overflow();
    test_back_pressure();
    test_full_memory();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- It writes each word into the byte-addressed instruction memory starting at BASE_ADDR. Byte [31:24] goes to the lowest address, the same order the fetch path reads.
- `busy` holds the PC at 0 while a program loads. The block then releases it and reports completion or error.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes.
- ADDR_W, 10, byte address width (log2 MEM_BYTES).
- BASE_ADDR, 0, byte address of the first loaded word; must be a multiple of 4.

Ports:
- CLK  input  1  single clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin receiving a frame; honoured only in IDLE, DONE or ERR.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- mem_we  output  1  one-cycle word write strobe.
- mem_waddr  output  ADDR_W  word-aligned byte address; memory writes [31:24] to addr, [23:16] to addr+1, [15:8] to addr+2, [7:0] to addr+3.
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  frame in progress; CPU PC is held while high.
- done  output  1  frame finished; level, held until the next start.
- err_checksum  output  1  checksum mismatch; level, held until the next start.
- err_overflow  output  1  declared length exceeds memory; level, held until the next start.

Behaviour:
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes (each word MSB first), then 1 checksum byte. The checksum equals the XOR of every preceding frame byte, including the length bytes.
- Reset (async): state = IDLE. Every output is 0, and the byte counter, word counter and XOR accumulator are all 0. Reset mid-frame aborts the frame with no further mem_we; words already written stay in memory.
- States and transitions:
  - IDLE: byte_ready=0. start goes to LEN_HI and clears done and both error flags.
  - LEN_HI: byte_ready=1; on transfer, latch len[15:8] and go to LEN_LO.
  - LEN_LO: byte_ready=1; on transfer, latch len[7:0]. Then:
    - if N*4 > MEM_BYTES-BASE_ADDR, go to ERR and set err_overflow;
    - else if N==0, go to CSUM;
    - else go to DATA.
  - DATA: byte_ready=1. Bytes shift into a 32-bit assembly register. On the 4th byte of a word, the next cycle asserts mem_we=1 for exactly one cycle with mem_waddr = BASE_ADDR + 4*word_idx and the completed word. word_idx then increments. After word N-1 the state goes to CSUM.
  - CSUM: byte_ready=1. On transfer, compare the byte with the accumulator and go to DONE; set err_checksum on mismatch.
  - DONE: done=1, byte_ready=0; start goes to LEN_HI.
  - ERR: byte_ready=0, busy=0; start goes to LEN_HI.
- busy=1 in LEN_HI, LEN_LO, DATA and CSUM.
- The pipelined write of the last data word overlaps the CSUM byte cycle; this is legal.
- Throughput: one byte per cycle with byte_valid held high. Gaps in byte_valid stall the loader without affecting the result.
- start while busy is ignored. Bytes presented while byte_ready=0 are not consumed.
- A checksum failure does not roll back written words. err_checksum and done are both high.
- Widths: the word counter is 16 bits. The overflow compare uses N*4 computed at 18 bits so it cannot wrap. The address adder is ADDR_W bits; it never wraps, because the overflow check prevents it.

Decomposition:
- Shared package `imem_pkg`:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
  - MEM_BYTES default;
  - WORD_BYTES=4.
- One sub-module, `word_assembler`: byte shift register plus 2-bit byte counter, producing a word_valid pulse. The FSM, XOR accumulator and write-port registers stay in the top.

Test Plan:
- Nominal two-word load: start, then 00 02 00 01 10 20 00 64 28 24 5B, back-to-back. Required response:
  - mem_we (addr 0, 0x00011020), then mem_we (addr 4, 0x00642824);
  - done=1, errors 0, busy low after the checksum byte;
  - fetching from PC 0 and PC 4 returns those words.
- Bad checksum: same frame ending 5A. Required: the same two writes occur, then done=1 and err_checksum=1.
- Zero length: 00 00 00. Required: no mem_we, done=1, errors 0.
- Overflow: 01 01 (257 words > 256). Required: ERR after the second byte, err_overflow=1, byte_ready=0, no mem_we. A following start and a valid frame load correctly with the flags cleared.
- Back-pressure: nominal frame with byte_valid toggling 1/0, plus start pulsed while busy. Required: results identical to the nominal case and the start is ignored.
- Reset mid-frame: assert RESET after 5 bytes. Required: all outputs 0 immediately (asynchronous) and no mem_we. After release, a new nominal frame completes correctly.
